// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: arbitrates fetch/data requests and steps one RAM access
// through ADDR/WAIT/CAPT/DONE. Optional WAIT timeout enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access_sequencer #(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [1:0] FETCH_TYPE     = 2'b10
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Fetch_Req,
  input  logic       Data_Req,
  input  logic       Data_RW,
  input  logic [1:0] Data_Type,
  input  logic       MOC,
  output logic       MAR_Ld,
  output logic       MDR_Ld,
  output logic       IR_Ld,
  output logic       MM,
  output logic       MOV,
  output logic       RW,
  output logic [1:0] Type,
  output logic       Fetch_Ack,
  output logic       Data_Ack,
  output logic       Busy,
  output logic       Err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_param_check
    $error("TIMEOUT_CYCLES must be in 1..31");
  end

  state_t     r_state;
  state_t     w_next_state;
  logic       r_kind_data;
  logic       r_rw;
  logic [1:0] r_type;
  logic       w_grant;
  logic       w_timeout_hit;
  logic       w_err_flag;

  assign w_grant = Data_Req || Fetch_Req;

  // Access attributes are frozen at grant so request changes mid-access are ignored.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_kind_data <= 1'b0;
      r_rw        <= 1'b0;
      r_type      <= 2'b00;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_grant) begin
        r_kind_data <= Data_Req;
        r_rw        <= Data_Req ? Data_RW : 1'b1;
        r_type      <= Data_Req ? Data_Type : FETCH_TYPE;
      end
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] r_wait_cnt;
  logic       r_timeout;

  assign w_timeout_hit = (r_state == S_WAIT) && !MOC && (r_wait_cnt == TO_LAST);
  assign w_err_flag    = r_timeout;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wait_cnt <= 5'd0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == S_ADDR) begin
        r_wait_cnt <= 5'd0;
      end else if (r_state == S_WAIT && !MOC) begin
        r_wait_cnt <= r_wait_cnt + 5'd1;
      end
      if (r_state == S_IDLE) begin
        r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign w_err_flag    = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    MAR_Ld       = 1'b0;
    MDR_Ld       = 1'b0;
    IR_Ld        = 1'b0;
    MM           = 1'b0;
    MOV          = 1'b0;
    RW           = 1'b0;
    Type         = 2'b00;
    Fetch_Ack    = 1'b0;
    Data_Ack     = 1'b0;
    Err          = 1'b0;
    Busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_next_state = S_ADDR;
      end
      S_ADDR: begin
        MAR_Ld = 1'b1;
        // Stores load write data from the ALU alongside the address.
        if (!r_rw) begin
          MDR_Ld = 1'b1;
          MM     = 1'b1;
        end
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        MOV  = 1'b1;
        RW   = r_rw;
        Type = r_type;
        if (MOC) begin
          w_next_state = r_rw ? S_CAPT : S_DONE;
        end else if (w_timeout_hit) begin
          w_next_state = S_DONE;
        end
      end
      S_CAPT: begin
        MOV  = 1'b1;
        RW   = r_rw;
        Type = r_type;
        if (r_kind_data) MDR_Ld = 1'b1;
        else             IR_Ld  = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        Fetch_Ack    = !r_kind_data;
        Data_Ack     = r_kind_data;
        Err          = w_err_flag;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of WAIT cycles with MOC low before abort, legal range 1..31.
REQ-002 The block SHALL have parameter FETCH_TYPE, default 2'b10: access-size code driven on type during instruction fetch (word).
REQ-003 The block SHALL have port Clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port Fetch_Req  input  1  instruction-fetch request, held high until Fetch_Ack.
REQ-006 The block SHALL have port Data_Req  input  1  load/store request, held high until Data_Ack.
REQ-007 The block SHALL have port Data_RW  input  1  1 = load (read), 0 = store (write).
REQ-008 The block SHALL have port Data_Type  input  2  access-size code for a data access.
REQ-009 The block SHALL have port MOC  input  1  memory-operation-complete from RAM.
REQ-010 The block SHALL have outputs MAR_Ld, MDR_Ld, IR_Ld, MM, MOV, RW, each 1 bit: datapath register loads, MDR-source mux select (1 = ALU, 0 = RAM data), memory valid, and read/write select (1 = read).
REQ-011 The block SHALL have output type  2  RAM access-size code.
REQ-012 The block SHALL have outputs Fetch_Ack, Data_Ack, Busy, Err, each 1 bit.

Function
REQ-013 States SHALL be IDLE, ADDR, WAIT, CAPT, DONE, with a 3-bit state register; outputs SHALL decode from registered state and latched fields only.
REQ-014 In IDLE: Data_Req high grants data; else Fetch_Req high grants fetch; else stay. Data SHALL win when both are high; fetch stays pending.
REQ-015 On grant, the block SHALL latch kind (fetch/data), RW (1 for fetch, Data_RW for data), and type (FETCH_TYPE or Data_Type), then go to ADDR.
REQ-016 ADDR (1 cycle): MAR_Ld=1; for a store, also MDR_Ld=1 and MM=1; then go to WAIT.
REQ-017 WAIT: MOV=1, RW and type driven from latched values; stay while MOC=0; on MOC=1 go to CAPT for reads, DONE for stores.
REQ-018 CAPT (1 cycle): MOV=1; fetch → IR_Ld=1; load → MDR_Ld=1, MM=0; then go to DONE.
REQ-019 DONE (1 cycle): MOV=0; one-cycle pulse on Fetch_Ack or Data_Ack per latched kind; then go to IDLE.
REQ-020 Minimum latency from grant edge to Ack SHALL be 4 cycles for reads and 3 cycles for stores with MOC high on the first WAIT cycle.
REQ-021 Busy SHALL be 1 in every state except IDLE.
REQ-022 Request changes after grant SHALL be ignored until return to IDLE; a request dropped before grant SHALL be treated as withdrawn.
REQ-023 Outputs not asserted by a state SHALL be 0; RW and type SHALL be 0 in IDLE.
REQ-024 Back-to-back: a request high in IDLE immediately after DONE SHALL be granted on that IDLE cycle (1 idle cycle minimum between accesses).

Reset
REQ-025 Rst_n low SHALL immediately force IDLE, clear latched fields, the timeout counter and Err, and drive all outputs to 0, including mid-access.
REQ-026 After Rst_n rises, the first grant SHALL occur on the first rising edge with a request high.

Configuration
REQ-027 Macro MEM_ACCESS_TIMEOUT_EN defined: a 5-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle with MOC=0; reaching TIMEOUT_CYCLES SHALL go to DONE with no CAPT load, and Err=1 during that DONE cycle together with Ack.
REQ-028 Macro MEM_ACCESS_TIMEOUT_EN undefined: no counter SHALL exist, WAIT SHALL hold indefinitely, and Err SHALL be tied to 0.

Verification
REQ-029 Fetch only, MOC high 2 cycles after MOV rises → MAR_Ld at cycle 1, IR_Ld at cycle 4, Fetch_Ack at cycle 5, type=2'b10 and RW=1 throughout WAIT.
REQ-030 Store with Data_Type=2'b01, MOC high on first WAIT cycle → ADDR asserts MAR_Ld, MDR_Ld and MM together, RW=0 in WAIT, no CAPT, Data_Ack at cycle 3.
REQ-031 Fetch_Req and Data_Req (load) rising on the same edge → load served first (MDR_Ld, MM=0, Data_Ack), then fetch granted on the first IDLE after DONE, followed by Fetch_Ack.
REQ-032 Rst_n pulled low during WAIT with MOV=1 → MOV, Busy, and all loads drop to 0 without a clock edge; no Ack is issued; state is IDLE after release.
REQ-033 With MEM_ACCESS_TIMEOUT_EN, MOC held 0 → exactly 16 WAIT cycles, then DONE with Data_Ack=1, Err=1, and no MDR_Ld; without the macro, Busy remains 1 and Err remains 0 for 100 cycles.
